// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, latency, FSM encodings and requester ids for mem_arbiter
package mem_pkg;

    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 3;
    localparam int MEM_LAT = 1;

    localparam int REQ_DRAW = 0;
    localparam int REQ_DISP = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// rtl/rd_tag_pipe.sv - DEPTH-stage shift register carrying {valid, id} of issued reads
module rd_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] id_q, id_d;

    always_comb begin
        valid_d    = valid_q;
        id_d       = id_q;
        valid_d[0] = in_valid;
        id_d[0]    = in_id;
        for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            id_d[i]    = id_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = id_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - draw/display arbiter driving the BRAM command bus with tagged read return
// Build option MEM_ARB_FIXED_PRIO_EN: display always wins, draw lock ignored, no RR pointer.
module mem_arbiter #(
    parameter int ADDR_W  = mem_pkg::ADDR_W,
    parameter int DATA_W  = mem_pkg::DATA_W,
    parameter int MEM_LAT = mem_pkg::MEM_LAT
) (
    input  logic              iClk,
    input  logic              iResetn,
    input  logic [1:0]        iReq,
    input  logic [1:0]        iWe,
    input  logic [1:0]        iLock,
    input  logic [1:0]        iBank,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iWdata0,
    input  logic [DATA_W-1:0] iWdata1,
    output logic [1:0]        oGnt,
    output logic [1:0]        oRdValid,
    output logic [DATA_W-1:0] oRdData,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemWren,
    output logic              oMemCs,
    input  logic [DATA_W-1:0] iMemQ
);
    import mem_pkg::*;

    state_e            state_q, state_d;
    logic [1:0]        lock_eff, idle_gnt, gnt_raw, gnt;
    logic              use_idle, gnt_any, gnt_id, we_sel;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d, rd_data_q, rd_data_d;
    logic              wren_q, wren_d, cs_q, cs_d;
    logic [1:0]        rd_valid_q, rd_valid_d;
    logic              tag_valid, tag_id;
`ifndef MEM_ARB_FIXED_PRIO_EN
    // Holds the requester preferred in the next contest, i.e. the one not served last.
    logic              rr_q, rr_d;
`endif

    always_comb begin
        lock_eff = iLock;
        idle_gnt = 2'b00;
`ifdef MEM_ARB_FIXED_PRIO_EN
        lock_eff[REQ_DRAW] = 1'b0;
        if (iReq[REQ_DISP])      idle_gnt = 2'b10;
        else if (iReq[REQ_DRAW]) idle_gnt = 2'b01;
`else
        if (&iReq) idle_gnt = rr_q ? 2'b10 : 2'b01;
        else       idle_gnt = iReq;
`endif
        use_idle = 1'b1;
        gnt_raw  = 2'b00;
        state_d  = ST_IDLE;
        case (state_q)
            ST_OWN0: if (iReq[0]) begin
                use_idle = 1'b0;
                gnt_raw  = 2'b01;
                state_d  = lock_eff[0] ? ST_OWN0 : ST_IDLE;
            end
            ST_OWN1: if (iReq[1]) begin
                use_idle = 1'b0;
                gnt_raw  = 2'b10;
                state_d  = lock_eff[1] ? ST_OWN1 : ST_IDLE;
            end
            default: use_idle = 1'b1;
        endcase
        // An owner that dropped its request frees the bus in the same cycle.
        if (use_idle) begin
            gnt_raw = idle_gnt;
            if (gnt_raw[0] && lock_eff[0])      state_d = ST_OWN0;
            else if (gnt_raw[1] && lock_eff[1]) state_d = ST_OWN1;
        end
        gnt = gnt_raw & {2{iResetn}};
`ifndef MEM_ARB_FIXED_PRIO_EN
        rr_d = gnt[1] ? 1'b0 : (gnt[0] ? 1'b1 : rr_q);
`endif
    end

    always_comb begin
        gnt_any = |gnt;
        gnt_id  = gnt[REQ_DISP];
        we_sel  = gnt_id ? iWe[1] : iWe[0];
        addr_d  = addr_q;
        data_d  = data_q;
        cs_d    = cs_q;
        wren_d  = gnt_any & we_sel;
        if (gnt_any) begin
            addr_d = gnt_id ? iAddr1 : iAddr0;
            data_d = gnt_id ? iWdata1 : iWdata0;
            cs_d   = gnt_id ? iBank[1] : iBank[0];
        end
        rd_valid_d = 2'b00;
        if (tag_valid) rd_valid_d[tag_id] = 1'b1;
        rd_data_d = iMemQ;
    end

    rd_tag_pipe #(
        .DEPTH(MEM_LAT + 1)
    ) u_rd_tag_pipe (
        .clk      (iClk),
        .rst_n    (iResetn),
        .in_valid (gnt_any & ~we_sel),
        .in_id    (gnt_id),
        .out_valid(tag_valid),
        .out_id   (tag_id)
    );

    always_ff @(posedge iClk or negedge iResetn) begin
        if (!iResetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wren_q     <= 1'b0;
            cs_q       <= 1'b0;
            rd_valid_q <= 2'b00;
            rd_data_q  <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wren_q     <= wren_d;
            cs_q       <= cs_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifndef MEM_ARB_FIXED_PRIO_EN
            rr_q       <= rr_d;
`endif
        end
    end

    assign oGnt     = gnt;
    assign oRdValid = rd_valid_q;
    assign oRdData  = rd_data_q;
    assign oMemAddr = addr_q;
    assign oMemData = data_q;
    assign oMemWren = wren_q;
    assign oMemCs   = cs_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a two-bank BRAM model
module tb_mem_arbiter;

    logic        iClk;
    logic        iResetn;
    logic [1:0]  iReq, iWe, iLock, iBank;
    logic [14:0] iAddr0, iAddr1;
    logic [2:0]  iWdata0, iWdata1;
    logic [1:0]  oGnt, oRdValid;
    logic [2:0]  oRdData;
    logic [14:0] oMemAddr;
    logic [2:0]  oMemData;
    logic        oMemWren, oMemCs;
    logic [2:0]  iMemQ;

    int errors = 0;
    int checks = 0;

    logic [2:0] bank0 [0:32767];
    logic [2:0] bank1 [0:32767];

    mem_arbiter dut (
        .iClk(iClk), .iResetn(iResetn), .iReq(iReq), .iWe(iWe), .iLock(iLock),
        .iBank(iBank), .iAddr0(iAddr0), .iAddr1(iAddr1), .iWdata0(iWdata0),
        .iWdata1(iWdata1), .oGnt(oGnt), .oRdValid(oRdValid), .oRdData(oRdData),
        .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemWren(oMemWren),
        .oMemCs(oMemCs), .iMemQ(iMemQ)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Memory controller model: one-cycle registered read, chip select picks the bank.
    always @(posedge iClk) begin
        if (oMemWren) begin
            if (oMemCs) bank1[oMemAddr] <= oMemData;
            else        bank0[oMemAddr] <= oMemData;
        end
        iMemQ <= oMemCs ? bank1[oMemAddr] : bank0[oMemAddr];
    end

    task automatic next_cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic clear_inputs();
        iReq = 2'b00; iWe = 2'b00; iLock = 2'b00; iBank = 2'b00;
        iAddr0 = '0; iAddr1 = '0; iWdata0 = '0; iWdata1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        iResetn = 1'b0;
        repeat (2) @(posedge iClk);
        #1 iResetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        iResetn = 1'b0;
        iReq = 2'b11;
        repeat (2) @(posedge iClk);
        #2;
        checks++;
        if ({oGnt, oRdValid, oRdData, oMemAddr, oMemData, oMemWren, oMemCs} !== '0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b rdv=%b rdd=%h addr=%h data=%h wren=%b cs=%b required all zero",
                     oGnt, oRdValid, oRdData, oMemAddr, oMemData, oMemWren, oMemCs);
        end
        iReq = 2'b00;
        #1 iResetn = 1'b1;
    endtask

    task automatic test_write_read();
        next_cycle();
        iReq = 2'b01; iWe = 2'b01; iBank = 2'b00; iAddr0 = 15'h0010; iWdata0 = 3'b101;
        #1;
        checks++;
        if (oGnt !== 2'b01) begin errors++; $display("FAIL wr_gnt got=%b exp=01", oGnt); end
        next_cycle();
        iWe = 2'b00;
        #1;
        checks++;
        if ({oMemWren, oMemCs, oMemAddr, oMemData} !== {1'b1, 1'b0, 15'h0010, 3'b101}) begin
            errors++;
            $display("FAIL wr_cmd wren=%b cs=%b addr=%h data=%b exp 1 0 0010 101", oMemWren, oMemCs, oMemAddr, oMemData);
        end
        checks++;
        if (oGnt !== 2'b01) begin errors++; $display("FAIL rd_gnt got=%b exp=01", oGnt); end
        next_cycle();
        iReq = 2'b00;
        #1;
        checks++;
        if (oMemWren !== 1'b0 || oRdValid !== 2'b00) begin
            errors++; $display("FAIL wren_one_cycle wren=%b rdv=%b exp 0 00", oMemWren, oRdValid);
        end
        next_cycle();
        #1;
        checks++;
        if (oRdValid !== 2'b00) begin errors++; $display("FAIL rd_early rdv=%b exp=00", oRdValid); end
        next_cycle();
        #1;
        checks++;
        if (oRdValid !== 2'b01 || oRdData !== 3'b101) begin
            errors++; $display("FAIL rd_after_wr rdv=%b data=%b exp 01 101", oRdValid, oRdData);
        end
    endtask

    task automatic test_bank_isolation();
        logic [1:0] exp_v [0:5];
        logic [2:0] exp_d [0:5];
        exp_v = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        exp_d = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            clear_inputs();
            iAddr0 = 15'h7FFF;
            case (i)
                0: begin iReq = 2'b01; iWe = 2'b01; iBank = 2'b01; iWdata0 = 3'b011; end
                1: begin iReq = 2'b01; iBank = 2'b00; end
                2: begin iReq = 2'b01; iBank = 2'b01; end
                default: iReq = 2'b00;
            endcase
            #1;
            checks++;
            if (oGnt !== (i < 3 ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL bank_gnt cyc=%0d got=%b", i, oGnt);
            end
            if (i >= 3) begin
                checks++;
                if (oRdValid !== exp_v[i] || (exp_v[i] != 2'b00 && oRdData !== exp_d[i])) begin
                    errors++;
                    $display("FAIL bank_rd cyc=%0d rdv=%b data=%b exp %b %b", i, oRdValid, oRdData, exp_v[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [0:8];
        do_reset();
        for (int i = 0; i < 9; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_g[i] = (i < 6) ? 2'b10 : 2'b00;
`else
            exp_g[i] = (i < 6) ? ((i % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
`endif
        end
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            clear_inputs();
            iReq = (i < 6) ? 2'b11 : 2'b00;
            iBank = 2'b10; iAddr0 = 15'h0010; iAddr1 = 15'h7FFF;
            #1;
            checks++;
            if (oGnt !== exp_g[i]) begin
                errors++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, oGnt, exp_g[i]);
            end
            if (i >= 3) begin
                checks++;
                if (oRdValid !== exp_g[i-3] ||
                    oRdData !== (exp_g[i-3] == 2'b01 ? 3'b101 : 3'b011)) begin
                    errors++;
                    $display("FAIL rr_tag cyc=%0d rdv=%b data=%b exp=%b", i, oRdValid, oRdData, exp_g[i-3]);
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [1:0] exp_g [0:5];
        logic       req1_pending;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_g = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif
        do_reset();
        req1_pending = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            clear_inputs();
            iReq  = {req1_pending, (i < 5) ? 1'b1 : 1'b0};
            iLock = {1'b0, (i < 4) ? 1'b1 : 1'b0};
            #1;
            checks++;
            if (oGnt !== exp_g[i]) begin
                errors++; $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", i, oGnt, exp_g[i]);
            end
            if (exp_g[i] == 2'b10) req1_pending = 1'b0;
        end
    endtask

    task automatic test_owner_drop();
        do_reset();
        next_cycle();
        iReq = 2'b01; iLock = 2'b01;
        #1;
        checks++;
        if (oGnt !== 2'b01) begin errors++; $display("FAIL drop_gnt0 got=%b exp=01", oGnt); end
        next_cycle();
        iReq = 2'b10; iLock = 2'b00;
        #1;
        checks++;
        if (oGnt !== 2'b10) begin errors++; $display("FAIL drop_no_bubble got=%b exp=10", oGnt); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            clear_inputs();
            iReq = 2'b01; iBank = 2'b01; iAddr0 = 15'h7FFF;
        end
        next_cycle();
        iResetn = 1'b0;
        #1;
        checks++;
        if ({oGnt, oRdValid, oRdData, oMemAddr, oMemData, oMemWren, oMemCs} !== '0) begin
            errors++;
            $display("FAIL async_reset gnt=%b rdv=%b rdd=%h addr=%h cs=%b required all zero",
                     oGnt, oRdValid, oRdData, oMemAddr, oMemCs);
        end
        next_cycle();
        iReq = 2'b00;
        iResetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            #1;
            checks++;
            if (oRdValid !== 2'b00) begin
                errors++; $display("FAIL post_reset_rdv cyc=%0d got=%b exp=00", i, oRdValid);
            end
        end
    endtask

    task automatic test_idle();
        clear_inputs();
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            #1;
            checks++;
            if (oGnt !== 2'b00 || oMemWren !== 1'b0) begin
                errors++; $display("FAIL idle cyc=%0d gnt=%b wren=%b exp 00 0", i, oGnt, oMemWren);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) begin
            bank0[a] = 3'b000;
            bank1[a] = 3'b000;
        end
        clear_inputs();
        iResetn = 1'b0;
        test_reset();
        test_write_read();
        test_bank_isolation();
        test_contention();
        test_lock();
        test_owner_drop();
        test_reset_midflight();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
